// File: rtl/seven_segment_scanner_if.sv
// Bus bundle between the display-data producer and the seven-segment scanner.
// Optional decimal-point signals exist only when SEVEN_SEG_DP_EN is defined.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    blank_lz;
  logic [6:0]              segments;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    frame_done;
`ifdef SEVEN_SEG_DP_EN
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    dp;

  modport master (
    output load, value_in, blank_lz, dp_in,
    input  segments, anodes, frame_done, dp
  );

  modport slave (
    input  load, value_in, blank_lz, dp_in,
    output segments, anodes, frame_done, dp
  );
`else
  modport master (
    output load, value_in, blank_lz,
    input  segments, anodes, frame_done
  );

  modport slave (
    input  load, value_in, blank_lz,
    output segments, anodes, frame_done
  );
`endif
endinterface

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver. Latches a packed BCD word and
// scans one digit at a time with a one-cycle dark gap between digits to avoid
// ghosting. Optional leading-zero blanking; frame_done marks each scan wrap.
// Optional decimal points are enabled by defining SEVEN_SEG_DP_EN.
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input logic                    clk,
  input logic                    rst,
  seven_segment_scanner_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0][3:0] disp;
  logic                       tc;
  logic                       last_digit;
  logic [NUM_DIGITS-1:0]      lz_mask;
  logic                       above_clear;
  logic [3:0]                 cur_nib;
  logic [6:0]                 cur_seg;
`ifdef SEVEN_SEG_DP_EN
  logic [NUM_DIGITS-1:0]      disp_dp;
`endif

  // Active-low segment patterns, bit6=a .. bit0=g; non-BCD codes blank.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign tc         = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));

  // Leading-zero mask: a zero digit is suppressed while everything above it is
  // zero or already blank. Digit 0 is never suppressed so "0" stays visible.
  always_comb begin
    lz_mask     = '0;
    above_clear = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_mask[k]  = above_clear && (disp[k] == 4'd0);
      above_clear = above_clear && ((disp[k] == 4'd0) || (disp[k] > 4'd9));
    end
  end

  // Segment pattern for the currently selected digit.
  always_comb begin
    cur_nib = disp[idx];
    if (bus.blank_lz && lz_mask[idx])
      cur_seg = 7'b1111111;
    else
      cur_seg = decode(cur_nib);
  end

  // Refresh down-time counter and digit index; index steps on terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tc) begin
      cnt <= '0;
      idx <= last_digit ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Display register; reset to all-blank so nothing shows until a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= {NUM_DIGITS{4'hF}};
`ifdef SEVEN_SEG_DP_EN
      disp_dp <= '0;
`endif
    end else if (bus.load) begin
      disp <= bus.value_in;
`ifdef SEVEN_SEG_DP_EN
      disp_dp <= bus.dp_in;
`endif
    end
  end

  // Output register, one cycle behind counter/index; terminal count is dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.segments   <= 7'b1111111;
      bus.anodes     <= '1;
      bus.frame_done <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
      bus.dp         <= 1'b1;
`endif
    end else if (tc) begin
      bus.segments   <= 7'b1111111;
      bus.anodes     <= '1;
      bus.frame_done <= last_digit;
`ifdef SEVEN_SEG_DP_EN
      bus.dp         <= 1'b1;
`endif
    end else begin
      bus.segments   <= cur_seg;
      bus.anodes     <= ~(NUM_DIGITS'(1) << idx);
      bus.frame_done <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
      bus.dp         <= ~disp_dp[idx];
`endif
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=4.
// Expected outputs come from a cycle-count reference model of the scan timing.
module tb_seven_segment_scanner;

  localparam int N = 4;
  localparam int R = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  seven_segment_scanner_if #(.NUM_DIGITS(N)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: edges since reset release and the latched word.
  int          m_n    = 0;
  logic [15:0] m_disp = 16'hFFFF;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_fd;
`ifdef SEVEN_SEG_DP_EN
  logic [3:0]  m_dp = 4'h0;
  logic        e_dp;
`endif

  logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'h7F, 7'h7F,
                               7'h7F, 7'h7F, 7'h7F, 7'h7F};

  function automatic int nib_of(logic [15:0] v, int d);
    return int'((v >> (4 * d)) & 16'hF);
  endfunction

  function automatic logic [6:0] ref_seg(logic [15:0] v, int d, bit blz);
    bit blank = 0;
    if (blz && d > 0 && nib_of(v, d) == 0) begin
      blank = 1;
      for (int j = d + 1; j < N; j++)
        if (nib_of(v, j) >= 1 && nib_of(v, j) <= 9) blank = 0;
    end
    return blank ? 7'h7F : dec_tab[nib_of(v, d)];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict the outputs after the edge, check them.
  task automatic tick(bit r, bit ld, logic [15:0] v, bit blz);
    int c, d;
    rst          = r;
    bus.load     = ld;
    bus.value_in = v;
    bus.blank_lz = blz;
`ifdef SEVEN_SEG_DP_EN
    bus.dp_in    = 4'($urandom);
`endif
    if (r) begin
      m_n = 0; m_disp = 16'hFFFF;
      e_seg = 7'h7F; e_an = 4'hF; e_fd = 1'b0;
`ifdef SEVEN_SEG_DP_EN
      m_dp = 4'h0; e_dp = 1'b1;
`endif
    end else begin
      m_n++;
      c = (m_n - 1) % R;
      d = ((m_n - 1) / R) % N;
      if (c == R - 1) begin
        e_seg = 7'h7F; e_an = 4'hF; e_fd = (d == N - 1);
`ifdef SEVEN_SEG_DP_EN
        e_dp = 1'b1;
`endif
      end else begin
        e_seg = ref_seg(m_disp, d, blz);
        e_an  = 4'hF & ~(4'h1 << d);
        e_fd  = 1'b0;
`ifdef SEVEN_SEG_DP_EN
        e_dp  = ~m_dp[d];
`endif
      end
      if (ld) begin
        m_disp = v;
`ifdef SEVEN_SEG_DP_EN
        m_dp = bus.dp_in;
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("segments", 32'(bus.segments), 32'(e_seg));
    check("anodes", 32'(bus.anodes), 32'(e_an));
    check("frame_done", 32'(bus.frame_done), 32'(e_fd));
`ifdef SEVEN_SEG_DP_EN
    check("dp", 32'(bus.dp), 32'(e_dp));
`endif
  endtask

  initial begin
    int   fd_count;
    bit   found;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.blank_lz = 1'b0;
`ifdef SEVEN_SEG_DP_EN
    bus.dp_in    = '0;
`endif
    @(negedge clk);

    // Reset held three cycles, with a load that must be ignored.
    for (int i = 0; i < 3; i++) tick(1, 1, 16'h5678, 0);
    check("rst_segments", 32'(bus.segments), 32'h7F);
    check("rst_anodes", 32'(bus.anodes), 32'hF);

    // First cycle after release: digit 0 selected, blank.
    tick(0, 0, 16'h0, 0);
    check("release_anodes", 32'(bus.anodes), 32'b1110);
    check("release_segments", 32'(bus.segments), 32'h7F);

    // Load 1234 and scan a frame.
    tick(0, 1, 16'h1234, 0);
    tick(0, 0, 16'h0, 0);
    check("digit0_is_4", 32'(bus.segments), 32'b1001100);
    for (int i = 0; i < 13; i++) tick(0, 0, 16'h0, 0);
    check("frame_end_pulse", 32'(bus.frame_done), 32'd1);

    // Free-run 32 cycles: exactly two frame_done pulses.
    fd_count = 0;
    for (int i = 0; i < 32; i++) begin
      tick(0, 0, 16'h0, 0);
      if (bus.frame_done) fd_count++;
    end
    check("frame_done_count", 32'(fd_count), 32'd2);

    // Leading-zero blanking cases.
    tick(0, 1, 16'h0070, 1);
    for (int i = 0; i < 16; i++) tick(0, 0, 16'h0, 1);
    tick(0, 1, 16'h0000, 1);
    for (int i = 0; i < 16; i++) tick(0, 0, 16'h0, 1);

    // Invalid codes.
    tick(0, 1, 16'hA9F5, 0);
    for (int i = 0; i < 16; i++) tick(0, 0, 16'h0, 0);

    // Reset while digit 2 is lit.
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick(0, 0, 16'h0, 0);
      if (bus.anodes == 4'b1011) found = 1;
    end
    check("find_digit2", 32'(found), 32'd1);
    tick(1, 0, 16'h0, 0);
    check("midscan_rst_anodes", 32'(bus.anodes), 32'hF);
    check("midscan_rst_segments", 32'(bus.segments), 32'h7F);
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 16'h0, 0);
      check("blank_after_rst", 32'(bus.segments), 32'h7F);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
           16'($urandom), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Multiplexed driver for NUM_DIGITS common-anode seven-segment digits, replacing the single-digit combinational decoder.
- Latches a packed BCD word, then time-multiplexes one digit at a time onto a shared segment bus. Per-digit anode enables are active-low.
- Adds optional leading-zero blanking, anti-ghosting dead time, and a frame-complete pulse.
- Sits between the counting/timing logic (lifetime result) and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles each digit stays selected; minimum 2.
- CNT_W, $clog2(REFRESH_DIV), width of the refresh counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- load  in  1  single-cycle strobe; capture value_in.
- value_in  in  4*NUM_DIGITS  packed BCD; nibble k is digit k, with digit 0 least significant.
- blank_lz  in  1  1 = blank leading zeros (sampled every cycle).
- segments  out  7  active-low segments, bit6=a .. bit0=g, registered.
- anodes  out  NUM_DIGITS  active-low digit enables, registered.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset (synchronous, active-high, one clock; the polarity and synchronicity are fixed):
  - segments=7'b1111111, anodes all 1, frame_done=0.
  - Refresh counter=0, digit index=0.
  - Display register: all nibbles 4'hF (blank).
- Display register:
  - On a clock edge with load=1 and rst=0, display register <= value_in.
  - The new data appears on the outputs when each digit is next driven. There is no handshake and no busy signal; back-to-back loads are allowed and the last one wins.
  - A load asserted during reset is ignored.
- Refresh counter:
  - Increments each cycle from 0 to REFRESH_DIV-1, then wraps to 0.
  - At the terminal count (REFRESH_DIV-1), the digit index advances by one. The index wraps from NUM_DIGITS-1 to 0.
- Output register (updated every clock, one cycle behind the counter and index):
  - Terminal-count cycle (dead time): anodes <= all 1 and segments <= 7'b1111111 for exactly that cycle, for anti-ghosting.
  - All other cycles: anodes <= ~(1<<index) and segments <= decode(nibble[index]).
  - Net visible pattern per digit: REFRESH_DIV-1 cycles lit, then 1 cycle dark.
- First cycle after reset release: anodes show digit 0 selected, displaying the blank nibble.
- decode, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Codes 10-15 produce 1111111 (blank).
- Leading-zero blanking (blank_lz=1):
  - Digit k is forced blank if its nibble is 0 and every nibble above k is 0 or blank (>9).
  - Digit 0 is never blanked by this rule, so a value of 0 shows a single "0".
- frame_done:
  - Registered, aligned with the output cycle in which the index changes from NUM_DIGITS-1 to 0, i.e. it coincides with the dead-time cycle.
- NUM_DIGITS=1: the index stays 0. frame_done pulses every REFRESH_DIV cycles, and the dead time still applies.
- Reset asserted mid-scan returns to the reset state on the next edge; no partial frame completes.

Optional Feature:
- Macro: SEVEN_SEG_DP_EN.
- Defined:
  - Adds input dp_in[NUM_DIGITS-1:0] (1 = point lit), captured into the display register on load.
  - Adds output dp (active-low, registered). dp is driven as ~dp_in_latched[index] in the same cycle as segments.
  - dp=1 during dead time and reset.
  - Leading-zero blanking does not blank dp.
- Undefined: neither port exists and no dp state is kept.

Test Plan:
- Directed scenarios assume NUM_DIGITS=4, REFRESH_DIV=4.
- Reset:
  - Stimulus: hold rst 3 cycles.
  - Required: segments=1111111, anodes=1111, frame_done=0 throughout.
  - After release: anodes=1110 with segments=1111111.
- Load and scan:
  - Stimulus: load value_in=16'h1234, blank_lz=0.
  - Required, in scan order: anodes 1110 -> segments 1001100 ("4"); 1101 -> 0000110; 1011 -> 0010010; 0111 -> 1001111.
  - Each digit lit 3 cycles, then 1 dark cycle with anodes=1111.
- frame_done:
  - Stimulus: free-run 32 cycles.
  - Required: frame_done high exactly once per 16 cycles, in the dead cycle after digit 3.
  - Required: never high in any other cycle.
- Leading-zero blanking:
  - Stimulus: value_in=16'h0070, blank_lz=1.
  - Required: digits 3,2 show 1111111; digit 1 shows 0001111; digit 0 shows 0000001.
  - Stimulus: value_in=16'h0000.
  - Required: only digit 0 shows 0000001.
- Invalid code and reset mid-scan:
  - Stimulus: value_in=16'hA9F5.
  - Required: digits 3 and 1 show 1111111.
  - Stimulus: assert rst while digit 2 is lit.
  - Required: next cycle all outputs are at reset values; after release the display is blank until a new load.
